// File: rtl/mac_lookup_arbiter.sv
// Round-robin arbiter sharing one MAC table lookup port among line cards.
// Grant order is kept in a FIFO so in-order results route back to owners.
module mac_lookup_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int KEY_WIDTH       = 114,
  parameter int ID_WIDTH        = 5,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                            clk,
  input  logic                            areset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]    req_key,
  input  logic [NUM_REQ*ID_WIDTH-1:0]     req_id,
  output logic                            lookup_valid,
  input  logic                            lookup_ready,
  output logic [KEY_WIDTH-1:0]            lookup_key,
  output logic [ID_WIDTH-1:0]             lookup_id,
  output logic [1:0]                      lookup_dest,
  input  logic                            tbl_done,
  input  logic                            tbl_hit,
  input  logic [5:0]                      tbl_dst_port,
  output logic [NUM_REQ-1:0]              rsp_done,
  output logic                            rsp_hit,
  output logic [5:0]                      rsp_dst_port,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                            err_underflow
);

  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;

  typedef enum logic {ARB, GRANT} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           rr_ptr;
  logic [1:0]           sel;
  logic                 found;
  int                   off;
  int                   best;
  logic                 grant;
  logic                 push;
  logic                 pop;
  logic                 empty;
  logic                 full;
  logic [KEY_WIDTH-1:0] key_sel;
  logic [ID_WIDTH-1:0]  id_sel;
  logic [1:0]           fifo [MAX_OUTSTANDING];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [1:0]           head;
  logic [NUM_REQ-1:0]   head_oh;

  assign empty = (outstanding == '0);
  assign full  = (outstanding == CW'(MAX_OUTSTANDING));
  assign pop   = tbl_done && !empty;
  assign head  = fifo[rd_ptr];

  // Pick the valid requester closest to rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    best  = NUM_REQ;
    off   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      off = (i + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
      if (req_valid[i] && off < best) begin
        best  = off;
        sel   = 2'(i);
        found = 1'b1;
      end
    end
  end

  // Mux the selected requester's key/ID and decode the FIFO head.
  always_comb begin
    key_sel = '0;
    id_sel  = '0;
    head_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == 2'(i)) begin
        key_sel = req_key[i*KEY_WIDTH +: KEY_WIDTH];
        id_sel  = req_id[i*ID_WIDTH +: ID_WIDTH];
      end
      head_oh[i] = (head == 2'(i));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state <= ARB;
    else           state <= state_nxt;
  end

  // Next state, grant strobe and handshake push.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    grant     = 1'b0;
    push      = 1'b0;
    unique case (state)
      ARB: begin
        if (found && !full) begin
          grant     = 1'b1;
          state_nxt = GRANT;
          for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = (sel == 2'(i));
        end
      end
      GRANT: begin
        if (lookup_ready) begin
          push      = 1'b1;
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // Lookup request registers and round-robin pointer.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      lookup_valid <= 1'b0;
      lookup_key   <= '0;
      lookup_id    <= '0;
      lookup_dest  <= '0;
      rr_ptr       <= '0;
    end else if (grant) begin
      lookup_valid <= 1'b1;
      lookup_key   <= key_sel;
      lookup_id    <= id_sel;
      lookup_dest  <= sel;
    end else if (push) begin
      lookup_valid <= 1'b0;
      rr_ptr       <= (lookup_dest == 2'(NUM_REQ - 1)) ? 2'd0
                                                        : 2'(lookup_dest + 2'd1);
    end
  end

  // Outstanding FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= lookup_dest;
  end

  // FIFO pointers, occupancy and result routing.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      outstanding   <= '0;
      rsp_done      <= '0;
      rsp_hit       <= 1'b0;
      rsp_dst_port  <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      outstanding <= outstanding + 1'b1;
      else if (pop && !push) outstanding <= outstanding - 1'b1;
      rsp_done <= pop ? head_oh : '0;
      if (tbl_done) begin
        rsp_hit      <= tbl_hit;
        rsp_dst_port <= tbl_dst_port;
      end
      if (tbl_done && empty) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_lookup_arbiter.sv
// Directed bench for mac_lookup_arbiter: single request, fairness,
// FIFO full, backpressure, simultaneous push/pop, underflow and reset.
module tb_mac_lookup_arbiter;

  localparam int NR = 2;
  localparam int KW = 114;
  localparam int IW = 5;
  localparam int MO = 8;

  logic            clk = 1'b0;
  logic            areset_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*KW-1:0] req_key;
  logic [NR*IW-1:0] req_id;
  logic            lookup_valid;
  logic            lookup_ready;
  logic [KW-1:0]   lookup_key;
  logic [IW-1:0]   lookup_id;
  logic [1:0]      lookup_dest;
  logic            tbl_done;
  logic            tbl_hit;
  logic [5:0]      tbl_dst_port;
  logic [NR-1:0]   rsp_done;
  logic            rsp_hit;
  logic [5:0]      rsp_dst_port;
  logic [3:0]      outstanding;
  logic            err_underflow;

  int errors = 0;
  int checks = 0;

  mac_lookup_arbiter #(
    .NUM_REQ(NR), .KEY_WIDTH(KW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .areset_n(areset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_id(req_id),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_key(lookup_key), .lookup_id(lookup_id),
    .lookup_dest(lookup_dest),
    .tbl_done(tbl_done), .tbl_hit(tbl_hit), .tbl_dst_port(tbl_dst_port),
    .rsp_done(rsp_done), .rsp_hit(rsp_hit), .rsp_dst_port(rsp_dst_port),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    areset_n = 1'b0;
    #2;
    areset_n = 1'b1;
    tick();
  endtask

  logic [KW-1:0] k_hold;
  logic [IW-1:0] i_hold;
  logic [1:0]    d_hold;
  int            gcount;
  logic          seen;

  initial begin
    areset_n     = 1'b0;
    req_valid    = '0;
    req_key      = '0;
    req_id       = '0;
    lookup_ready = 1'b0;
    tbl_done     = 1'b0;
    tbl_hit      = 1'b0;
    tbl_dst_port = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", lookup_valid, 0);
    check("rst_outst", outstanding, 0);
    check("rst_done", rsp_done, 0);
    check("rst_err", err_underflow, 0);
    check("rst_ready", req_ready, 0);
    areset_n = 1'b1;
    tick();

    // Single request
    req_key[0 +: KW]  = 114'h1234;
    req_key[KW +: KW] = 114'hABCDE;
    req_id[0 +: IW]   = 5'd3;
    req_id[IW +: IW]  = 5'd17;
    req_valid    = 2'b01;
    lookup_ready = 1'b1;
    #1;
    check("s_req_ready", req_ready, 2'b01);
    tick();
    check("s_lv", lookup_valid, 1);
    check("s_dest", lookup_dest, 0);
    check("s_id", lookup_id, 3);
    check("s_key", lookup_key, 114'h1234);
    req_valid = 2'b00;
    tick();
    check("s_lv_drop", lookup_valid, 0);
    check("s_outst1", outstanding, 1);
    tbl_done = 1'b1; tbl_hit = 1'b1; tbl_dst_port = 6'd7;
    tick();
    tbl_done = 1'b0; tbl_hit = 1'b0; tbl_dst_port = 6'd0;
    check("s_rsp_done", rsp_done, 2'b01);
    check("s_rsp_hit", rsp_hit, 1);
    check("s_rsp_port", rsp_dst_port, 7);
    check("s_outst0", outstanding, 0);
    tick();
    check("s_done_pulse", rsp_done, 0);
    check("s_hit_hold", rsp_hit, 1);

    // Fairness, then FIFO full
    reset_dut();
    req_valid    = 2'b11;
    lookup_ready = 1'b1;
    gcount = 0;
    for (int c = 0; c < 40 && gcount < 8; c++) begin
      tick();
      if (lookup_valid) begin
        check("f_dest", lookup_dest, 2'(gcount % 2));
        gcount++;
      end
    end
    check("f_grants", gcount, 8);
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (lookup_valid) seen = 1'b1;
    end
    check("full_no9", seen, 0);
    check("full_outst", outstanding, 8);
    tbl_done = 1'b1;
    tick();
    tbl_done = 1'b0;
    check("f_rsp0", rsp_done, 2'b01);
    check("full_outst7", outstanding, 7);
    seen = lookup_valid;
    for (int c = 0; c < 5 && !seen; c++) begin
      tick();
      seen = lookup_valid;
    end
    check("full_9th", seen, 1);
    check("full_9th_dest", lookup_dest, 0);
    req_valid = 2'b00;
    tick();
    check("full_outst8", outstanding, 8);
    for (int k = 1; k < 4; k++) begin
      tbl_done = 1'b1;
      tick();
      tbl_done = 1'b0;
      check("f_rsp", rsp_done, (k % 2) ? 2'b10 : 2'b01);
      tick();
    end

    // Backpressure and simultaneous push/pop
    reset_dut();
    req_valid    = 2'b01;
    lookup_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    check("bp_outst1", outstanding, 1);
    lookup_ready = 1'b0;
    req_valid    = 2'b10;
    tick();
    check("bp_lv", lookup_valid, 1);
    check("bp_dest", lookup_dest, 1);
    check("bp_key", lookup_key, 114'hABCDE);
    req_valid = 2'b11;
    k_hold = lookup_key;
    i_hold = lookup_id;
    d_hold = lookup_dest;
    repeat (5) begin
      tick();
      check("bp_hold_v", lookup_valid, 1);
      check("bp_hold_k", lookup_key, k_hold);
      check("bp_hold_i", lookup_id, i_hold);
      check("bp_hold_d", lookup_dest, d_hold);
      check("bp_ready0", req_ready, 0);
    end
    req_valid    = 2'b00;
    lookup_ready = 1'b1;
    tbl_done = 1'b1; tbl_hit = 1'b0; tbl_dst_port = 6'd9;
    tick();
    tbl_done = 1'b0;
    check("pp_outst", outstanding, 1);
    check("pp_rsp", rsp_done, 2'b01);
    check("pp_port", rsp_dst_port, 9);
    check("pp_lv", lookup_valid, 0);
    tbl_done = 1'b1; tbl_dst_port = 6'd11;
    tick();
    tbl_done = 1'b0;
    check("pp_rsp2", rsp_done, 2'b10);
    check("pp_outst0", outstanding, 0);

    // Underflow and mid-grant reset
    tbl_done = 1'b1;
    tick();
    tbl_done = 1'b0;
    check("uf_err", err_underflow, 1);
    check("uf_rsp", rsp_done, 0);
    check("uf_outst", outstanding, 0);
    tick();
    check("uf_sticky", err_underflow, 1);
    req_valid    = 2'b01;
    lookup_ready = 1'b0;
    tick();
    check("ar_lv_pre", lookup_valid, 1);
    req_valid = 2'b00;
    #2;
    areset_n = 1'b0;
    #1;
    check("ar_lv", lookup_valid, 0);
    check("ar_err", err_underflow, 0);
    check("ar_outst", outstanding, 0);
    areset_n = 1'b1;
    tick();
    tick();
    check("ar_idle", lookup_valid, 0);
    check("ar_rsp", rsp_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
